// File: rtl/dac_prog_pkg.sv
// Shared state encoding and table sizing for the DAC programming scheduler.
// Constants and types only: no logic, no latency, no flow control.
package dac_prog_pkg;

    localparam int NUM_DAC = 8;
    localparam int ADDR_W  = 3;
    localparam int LEVEL_W = 8;
    // One extra pointer bit encodes "past the last channel" for the end-of-sweep check.
    localparam int PTR_W   = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/dac_level_table.sv
// Per-channel DAC level table: one synchronous write port, one async read port.
// Write lands on the next clk edge; the read is combinational with no backpressure.
module dac_level_table
    import dac_prog_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_wadd,
    input  logic [LEVEL_W-1:0] i_wdat,
    input  logic [ADDR_W-1:0]  i_radd,
    output logic [LEVEL_W-1:0] o_rdat
);

    logic [LEVEL_W-1:0] r_mem [NUM_DAC];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_DAC; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_wadd] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_radd];

endmodule

// File: rtl/dac_prog_scheduler.sv
// Sweeps enabled DAC channels and issues one table-driven write per channel to the chip programmer.
// One dac_we per command, then stalls in WAIT_DONE until prog_done or timeout.
module dac_prog_scheduler
    import dac_prog_pkg::*;
#(
    parameter int NUM_DAC        = dac_prog_pkg::NUM_DAC,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_add,
    input  logic [LEVEL_W-1:0] cfg_level,
    input  logic [NUM_DAC-1:0] cfg_mask,
    input  logic               start,
    input  logic               cont,
    input  logic               stop,
    input  logic               prog_done,
    output logic               dac_we,
    output logic [ADDR_W-1:0]  dac_add,
    output logic [LEVEL_W-1:0] dac_level_voltage,
    output logic               busy,
    output logic               sweep_done,
    output logic               err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    state_t             w_next;
    logic [PTR_W-1:0]   r_ptr;
    logic [NUM_DAC-1:0] r_mask;
    logic               r_cont;
    logic               r_stop_pend;
    logic               r_err;
    logic [ADDR_W-1:0]  r_add;
    logic [LEVEL_W-1:0] r_level;
    logic [TMO_W-1:0]   r_tmo;
    logic [LEVEL_W-1:0] w_rd_level;
    logic               w_past_end;
    logic               w_chan_en;
    logic               w_tmo_hit;

    dac_level_table u_table (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (cfg_we),
        .i_wadd (cfg_add),
        .i_wdat (cfg_level),
        .i_radd (r_ptr[ADDR_W-1:0]),
        .o_rdat (w_rd_level)
    );

    assign w_past_end = (r_ptr == PTR_W'(NUM_DAC));
    assign w_chan_en  = !w_past_end && r_mask[r_ptr[ADDR_W-1:0]];
    assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (stop) begin
                    w_next = ST_IDLE;
                end else if (w_past_end) begin
                    // An empty mask in continuous mode would spin forever; drop out instead.
                    if (!r_cont || (r_mask == '0)) w_next = ST_IDLE;
                end else if (w_chan_en) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = stop ? ST_IDLE : ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (prog_done) begin
                    w_next = (stop || r_stop_pend) ? ST_IDLE : ST_SCAN;
                end else if (w_tmo_hit) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_mask      <= '0;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_err       <= 1'b0;
            r_add       <= '0;
            r_level     <= '0;
            r_tmo       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask      <= cfg_mask;
                        r_cont      <= cont;
                        r_ptr       <= '0;
                        r_err       <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!stop) begin
                        if (w_past_end)      r_ptr <= '0;
                        else if (!w_chan_en) r_ptr <= r_ptr + PTR_W'(1);
                    end
                end
                ST_ISSUE: begin
                    // Capture the command so later table writes cannot disturb it.
                    if (!stop) begin
                        r_add   <= r_ptr[ADDR_W-1:0];
                        r_level <= w_rd_level;
                    end
                    r_tmo       <= '0;
                    r_stop_pend <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (stop) r_stop_pend <= 1'b1;
                    if (prog_done)      r_ptr <= r_ptr + PTR_W'(1);
                    else if (w_tmo_hit) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dac_we            = (r_state == ST_ISSUE) && !stop;
        dac_add           = (r_state == ST_ISSUE) ? r_ptr[ADDR_W-1:0] : r_add;
        dac_level_voltage = (r_state == ST_ISSUE) ? w_rd_level : r_level;
        busy              = (r_state != ST_IDLE);
        sweep_done        = (r_state == ST_SCAN) && !stop && w_past_end && !r_cont;
        err               = r_err;
    end

endmodule

// File: tb/tb_dac_prog_scheduler.sv
// Scoreboarded bench for dac_prog_scheduler: directed sweeps, timeout, stop and reset cases.
module tb_dac_prog_scheduler;

    localparam int TMO = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_add = '0;
    logic [7:0] cfg_level = '0;
    logic [7:0] cfg_mask = '0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       stop = 1'b0;
    logic       prog_done = 1'b0;
    logic       dac_we;
    logic [2:0] dac_add;
    logic [7:0] dac_level_voltage;
    logic       busy;
    logic       sweep_done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit       is_done;
        bit [2:0] add;
        bit [7:0] lvl;
    } exp_t;

    exp_t q[$];

    dac_prog_scheduler #(.NUM_DAC(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_we            (cfg_we),
        .cfg_add           (cfg_add),
        .cfg_level         (cfg_level),
        .cfg_mask          (cfg_mask),
        .start             (start),
        .cont              (cont),
        .stop              (stop),
        .prog_done         (prog_done),
        .dac_we            (dac_we),
        .dac_add           (dac_add),
        .dac_level_voltage (dac_level_voltage),
        .busy              (busy),
        .sweep_done        (sweep_done),
        .err               (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: every command or sweep_done the DUT presents must match the queue head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && dac_we) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_cmd: unexpected dac_we add=%0d level=%0d", dac_add, dac_level_voltage);
            end else begin
                e = q.pop_front();
                if (e.is_done || e.add != dac_add || e.lvl != dac_level_voltage) begin
                    n_err++;
                    $display("FAIL sb_cmd: got cmd (%0d,%0d) expected done=%0d cmd (%0d,%0d)",
                             dac_add, dac_level_voltage, e.is_done, e.add, e.lvl);
                end
            end
        end
        if (!rst && sweep_done) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL sb_done: unexpected sweep_done");
            end else begin
                e = q.pop_front();
                if (!e.is_done) begin
                    n_err++;
                    $display("FAIL sb_done: got sweep_done expected cmd (%0d,%0d)", e.add, e.lvl);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic push_cmd(input bit [2:0] a, input bit [7:0] l);
        exp_t e;
        e.is_done = 1'b0;
        e.add     = a;
        e.lvl     = l;
        q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.add     = '0;
        e.lvl     = '0;
        q.push_back(e);
    endtask

    task automatic cfg_write(input bit [2:0] a, input bit [7:0] l);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_add = a; cfg_level = l;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input bit [7:0] m, input bit c);
        @(posedge clk); #1;
        cfg_mask = m; cont = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_we(input string nm, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dac_we) seen = 1'b1;
        end
        chk(nm, seen, 1);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk(nm, idle, 1);
    endtask

    // Programmer model: answer dly cycles after the command, checking it is held stable.
    task automatic respond(input string nm, input int dly, input bit [2:0] a, input bit [7:0] l);
        repeat (dly) @(posedge clk);
        #2;
        chk({nm, "_we_low"}, dac_we, 0);
        chk({nm, "_add_hold"}, dac_add, a);
        chk({nm, "_lvl_hold"}, dac_level_voltage, l);
        prog_done = 1'b1;
        @(posedge clk); #1;
        prog_done = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dac_we"}, dac_we, 0);
        chk({nm, "_dac_add"}, dac_add, 0);
        chk({nm, "_level"}, dac_level_voltage, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_sweep_done"}, sweep_done, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    initial begin
        int n;
        bit got;

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-channel sweep: (1,5) then (2,8), then sweep_done
        cfg_write(3'd1, 8'd5);
        cfg_write(3'd2, 8'd8);
        push_cmd(3'd1, 8'd5);
        push_cmd(3'd2, 8'd8);
        push_done();
        do_start(8'h06, 1'b0);
        wait_we("sweep_we1", 20);
        respond("sweep_c1", 20, 3'd1, 8'd5);
        wait_we("sweep_we2", 20);
        respond("sweep_c2", 20, 3'd2, 8'd8);
        wait_idle("sweep_idle", 20);
        chk("sweep_err", err, 0);

        // Empty mask: sweep_done within 9 cycles, no command
        push_done();
        do_start(8'h00, 1'b0);
        n = 0; got = 1'b0;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk);
            if (sweep_done) begin got = 1'b1; n = i; end
        end
        chk("empty_done_seen", got, 1);
        chk("empty_done_by9", (n <= 9) ? 1 : 0, 1);
        @(negedge clk);
        chk("empty_busy_low", busy, 0);

        // Continuous single channel, stop during WAIT_DONE
        cfg_write(3'd2, 8'd7);
        repeat (3) push_cmd(3'd2, 8'd7);
        do_start(8'h04, 1'b1);
        wait_we("cont_we1", 20);
        respond("cont_c1", 6, 3'd2, 8'd7);
        wait_we("cont_we2", 20);
        respond("cont_c2", 6, 3'd2, 8'd7);
        wait_we("cont_we3", 20);
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        chk("stop_still_busy", busy, 1);
        respond("cont_c3", 8, 3'd2, 8'd7);
        @(negedge clk);
        chk("stop_idle", busy, 0);
        repeat (20) @(negedge clk);
        chk("stop_stays_idle", busy, 0);

        // Table update during WAIT_DONE: held level stays 8, next visit issues 9
        cfg_write(3'd2, 8'd8);
        push_cmd(3'd2, 8'd8);
        push_cmd(3'd2, 8'd9);
        do_start(8'h04, 1'b1);
        wait_we("upd_we1", 20);
        cfg_write(3'd2, 8'd9);
        respond("upd_c1", 10, 3'd2, 8'd8);
        wait_we("upd_we2", 20);
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        respond("upd_c2", 4, 3'd2, 8'd9);
        wait_idle("upd_idle", 4);

        // prog_done in the last timeout cycle counts as success
        cfg_write(3'd0, 8'h33);
        push_cmd(3'd0, 8'h33);
        push_done();
        do_start(8'h01, 1'b0);
        wait_we("edge_we", 20);
        respond("edge_c", TMO, 3'd0, 8'h33);
        wait_idle("edge_idle", 20);
        chk("edge_err", err, 0);

        // Timeout: err after exactly TMO WAIT_DONE cycles, no sweep_done
        push_cmd(3'd0, 8'h33);
        do_start(8'h01, 1'b0);
        wait_we("tmo_we", 20);
        n = 0; got = 1'b0;
        for (int i = 0; i < TMO + 100 && !got; i++) begin
            @(negedge clk);
            if (err) got = 1'b1;
            else n++;
        end
        chk("tmo_err_set", got, 1);
        chk("tmo_cycles", n, TMO);
        chk("tmo_idle", busy, 0);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", err, 1);
        push_done();
        do_start(8'h00, 1'b0);
        @(negedge clk);
        chk("tmo_err_cleared", err, 0);
        wait_idle("tmo_restart_idle", 20);

        // Async reset mid-WAIT_DONE, later prog_done ignored
        push_cmd(3'd0, 8'h33);
        do_start(8'h01, 1'b0);
        wait_we("rstw_we", 20);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_reset_outputs("rstw_async");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1; prog_done = 1'b1;
        @(posedge clk); #1; prog_done = 1'b0;
        repeat (10) @(negedge clk);
        chk("rstw_busy_after", busy, 0);
        chk("rstw_level_after", dac_level_voltage, 0);

        chk("sb_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_prog_scheduler.md
DAC_PROG_SCHEDULER -- requirements
Module: dac_prog_scheduler

Interface
REQ-001 Parameter NUM_DAC, default 8: number of DAC channels in the target table (address width 3).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum clk cycles to wait for prog_done per command.
REQ-003 Port clk  in  1: single clock for all logic.
REQ-004 Port rst  in  1: reset, asynchronous and active-high.
REQ-005 Port cfg_we  in  1: writes cfg_level into table entry cfg_add on this cycle.
REQ-006 Port cfg_add  in  3: table entry index for cfg_we.
REQ-007 Port cfg_level  in  8: DAC level value to store.
REQ-008 Port cfg_mask  in  8: per-channel enable; bit i=1 includes channel i in a sweep; sampled at start.
REQ-009 Port start  in  1: single-cycle pulse that begins a sweep.
REQ-010 Port cont  in  1: continuous mode; sampled at start.
REQ-011 Port stop  in  1: requests sweep termination.
REQ-012 Port prog_done  in  1: single-cycle pulse from the chip programmer when the serial DAC write completes.
REQ-013 Port dac_we  out  1: command valid to the chip programmer.
REQ-014 Port dac_add  out  3: DAC address of the current command.
REQ-015 Port dac_level_voltage  out  8: DAC level of the current command.
REQ-016 Port busy  out  1: high in every state except IDLE.
REQ-017 Port sweep_done  out  1: one-cycle pulse when a sweep ends normally.
REQ-018 Port err  out  1: sticky timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, SCAN, ISSUE, WAIT_DONE.
REQ-020 IDLE: on start, latch cfg_mask and cont, clear the channel pointer to 0, clear err, go to SCAN; start while busy SHALL be ignored.
REQ-021 SCAN: skip disabled channels at one channel per cycle; on an enabled channel, go to ISSUE; past channel 7, wrap to 0 if cont=1 (else pulse sweep_done, go IDLE).
REQ-022 ISSUE: drive dac_add=pointer and dac_level_voltage=table[pointer] (latched in this cycle), assert dac_we for exactly one cycle, go to WAIT_DONE.
REQ-023 WAIT_DONE: hold dac_add and dac_level_voltage stable, dac_we=0; on prog_done, increment the pointer and go to SCAN.
REQ-024 The timeout counter SHALL clear on entry to WAIT_DONE; at TIMEOUT_CYCLES without prog_done, set err and go to IDLE with no sweep_done.
REQ-025 prog_done in the same cycle as timeout expiry SHALL count as success.
REQ-026 An all-zero latched mask SHALL produce sweep_done within 9 cycles of start, with no dac_we; in cont mode it SHALL return to IDLE without sweep_done.
REQ-027 stop in SCAN or ISSUE-pending SHALL return to IDLE next cycle. Stop in WAIT_DONE SHALL finish the current command first, then go to IDLE. Neither case pulses sweep_done.
REQ-028 cfg_we during a sweep SHALL update the table immediately; a command already issued SHALL keep its latched level, and the new value applies on the next visit.
REQ-029 prog_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-030 On rst: state IDLE, pointer 0, table entries 0, dac_we 0, dac_add 0, dac_level_voltage 0, busy 0, sweep_done 0, err 0, timeout counter 0.
REQ-031 Reset asserted mid-sweep SHALL abort immediately with no further dac_we.

Structure
REQ-032 State encoding, NUM_DAC and the DAC address/level widths SHALL live in a shared package, dac_prog_pkg.
REQ-033 The 8x8 target table SHALL be a sub-module, dac_level_table (one write port, one async read port).

Verification
REQ-034 Write table[1]=5 and table[2]=8, mask=0x06, start, respond with prog_done 20 cycles after each dac_we -> commands (1,5) then (2,8), then one sweep_done.
REQ-035 Mask=0x00, start -> no dac_we, sweep_done within 9 cycles, busy low afterwards.
REQ-036 cont=1, mask=0x04, table[2]=7 -> repeated (2,7) commands; stop during WAIT_DONE -> current command completes, then IDLE with no sweep_done.
REQ-037 Mask=0x01, never send prog_done -> err=1 after exactly TIMEOUT_CYCLES, IDLE, and the next start clears err.
REQ-038 Assert rst mid-WAIT_DONE -> all outputs return to reset values asynchronously, and a later prog_done is ignored.
REQ-039 Write table[2]=9 while the (2,8) command is in WAIT_DONE -> dac_level_voltage holds 8, and the next cont visit issues 9.
